// File: rtl/wb_arbiter.sv
// wb_arbiter: captures a 4-lane MEM-stage bundle and drains its register
// writes onto two write ports, oldest lanes first, two per cycle.
module wb_arbiter #(
  parameter int NLANE = 4,
  parameter int NPORT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NLANE-1:0]       lane_en,
  input  logic [32*NLANE-1:0]    ALU_o,
  input  logic [32*NLANE-1:0]    IR,
  input  logic [32*NLANE-1:0]    LMD,
  input  logic [2*NLANE-1:0]     cmd_type,
  output logic [NPORT-1:0]       wr_en,
  output logic [5*NPORT-1:0]     wr_addr,
  output logic [32*NPORT-1:0]    wr_data,
  output logic                   busy,
  output logic [15:0]            retired
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam logic [1:0] CMD_LOAD = 2'b01;

  logic [0:0]                  state_q, state_d;
  logic [NLANE-1:0]            pending_q, pending_d;
  logic [NLANE-1:0][4:0]       dest_q;
  logic [NLANE-1:0][31:0]      data_q;
  logic [15:0]                 retired_q, retired_d;

  logic [NLANE-1:0]            cap_mask;
  logic [NLANE-1:0][4:0]       cap_dest;
  logic [NLANE-1:0][31:0]      cap_data;

  logic                        has_first, has_second, same_dest;
  logic [1:0]                  first_idx, second_idx;
  logic [NLANE-1:0]            issued;
  logic [2:0]                  pop_cnt;
  logic                        accept;
  logic                        unused_ir;

  // Only IR[20:11] of each lane carries a destination field.
  always_comb unused_ir = ^(IR & ~{NLANE{32'h001F_F800}});

  // Decode each incoming lane into destination, write data and write-valid.
  always_comb begin
    cap_mask = '0;
    cap_dest = '0;
    cap_data = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      if (cmd_type[2*i +: 2] == CMD_LOAD) begin
        cap_dest[i] = IR[32*i+16 +: 5];
        cap_data[i] = LMD[32*i +: 32];
      end else begin
        cap_dest[i] = IR[32*i+11 +: 5];
        cap_data[i] = ALU_o[32*i +: 32];
      end
      cap_mask[i] = lane_en[i] & ~cmd_type[2*i+1] & (cap_dest[i] != '0);
    end
  end

  // Find the two lowest-index pending lanes and the pending population.
  always_comb begin
    has_first  = 1'b0;
    has_second = 1'b0;
    first_idx  = '0;
    second_idx = '0;
    pop_cnt    = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      pop_cnt = pop_cnt + 3'(pending_q[i]);
      if (pending_q[i]) begin
        if (!has_first) begin
          has_first = 1'b1;
          first_idx = 2'(i);
        end else if (!has_second) begin
          has_second = 1'b1;
          second_idx = 2'(i);
        end
      end
    end
    same_dest = has_second && (dest_q[first_idx] == dest_q[second_idx]);
  end

  // Drive the write ports; a same-destination pair collapses to the younger lane.
  always_comb begin
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    issued  = '0;
    if (has_first) begin
      issued[first_idx] = 1'b1;
      if (has_second) begin
        issued[second_idx] = 1'b1;
      end
      if (has_second && !same_dest) begin
        wr_en         = 2'b11;
        wr_addr[4:0]  = dest_q[first_idx];
        wr_data[31:0] = data_q[first_idx];
        wr_addr[9:5]  = dest_q[second_idx];
        wr_data[63:32] = data_q[second_idx];
      end else if (has_second) begin
        wr_en         = 2'b01;
        wr_addr[4:0]  = dest_q[second_idx];
        wr_data[31:0] = data_q[second_idx];
      end else begin
        wr_en         = 2'b01;
        wr_addr[4:0]  = dest_q[first_idx];
        wr_data[31:0] = data_q[first_idx];
      end
    end
  end

  // Next-state: a new bundle can only arrive while everything pending issues
  // this cycle, so its mask simply replaces the old one.
  always_comb begin
    in_ready  = (pop_cnt <= 3'd2);
    accept    = in_valid & in_ready;
    pending_d = accept ? cap_mask : (pending_q & ~issued);
    state_d   = (pending_d != '0) ? DRAIN : IDLE;
    retired_d = retired_q + 16'(wr_en[0]) + 16'(wr_en[1]);
  end

  // State, pending mask, retired counter and latched bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      retired_q <= '0;
      dest_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      retired_q <= retired_d;
      if (accept) begin
        dest_q <= cap_dest;
        data_q <= cap_data;
      end
    end
  end

  assign busy    = (state_q == DRAIN);
  assign retired = retired_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table plus hand sequences for reset,
// back-to-back streaming and retired-counter wrap.
module tb_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   lane_en = '0;
  logic [127:0] ALU_o = '0;
  logic [127:0] IR = '0;
  logic [127:0] LMD = '0;
  logic [7:0]   cmd_type = '0;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         busy;
  logic [15:0]  retired;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.NLANE(4), .NPORT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .lane_en(lane_en), .ALU_o(ALU_o), .IR(IR), .LMD(LMD), .cmd_type(cmd_type),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            v;
    logic [3:0]      en;
    logic [3:0][1:0] ct;
    logic [3:0][4:0] d;
    logic [3:0][31:0] x;
    logic [1:0]      wen;
    logic [4:0]      a0, a1;
    logic [31:0]     d0, d1;
    logic            rdy, bsy;
    logic [15:0]     ret;
  } vec_t;

  typedef struct {
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Destination goes in the field matching the class; the other field and the
  // other data bus carry a decoy so a wrong selection shows up.
  task automatic drive(input logic v, input logic [3:0] en, input logic [3:0][1:0] ct,
                       input logic [3:0][4:0] d, input logic [3:0][31:0] x);
    logic [127:0] ir, alu, lmd;
    ir = '0; alu = '0; lmd = '0;
    for (int i = 0; i < 4; i++) begin
      if (ct[i] == 2'b01) begin
        ir[32*i+16 +: 5] = d[i];
        ir[32*i+11 +: 5] = ~d[i];
        lmd[32*i +: 32]  = x[i];
        alu[32*i +: 32]  = ~x[i];
      end else begin
        ir[32*i+11 +: 5] = d[i];
        ir[32*i+16 +: 5] = ~d[i];
        alu[32*i +: 32]  = x[i];
        lmd[32*i +: 32]  = ~x[i];
      end
    end
    in_valid = v; lane_en = en; cmd_type = ct; IR = ir; ALU_o = alu; LMD = lmd;
  endtask

  task automatic addv(input logic v, input logic [3:0] en, input logic [3:0][1:0] ct,
                      input logic [3:0][4:0] d, input logic [3:0][31:0] x,
                      input logic [1:0] wen, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1,
                      input logic rdy, input logic bsy, input logic [15:0] ret);
    vec_t r;
    r.v = v; r.en = en; r.ct = ct; r.d = d; r.x = x;
    r.wen = wen; r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1;
    r.rdy = rdy; r.bsy = bsy; r.ret = ret;
    vq.push_back(r);
  endtask

  task automatic chk_idle(input string nm, input logic [15:0] ret);
    chk({nm, ".wr_en"}, 32'(wr_en), 32'h0);
    chk({nm, ".busy"}, 32'(busy), 32'h0);
    chk({nm, ".in_ready"}, 32'(in_ready), 32'h1);
    chk({nm, ".retired"}, 32'(retired), 32'(ret));
  endtask

  localparam logic [3:0][1:0] ALL_ALU = {2'b00, 2'b00, 2'b00, 2'b00};

  initial begin
    logic [3:0][1:0]  ct;
    logic [3:0][4:0]  d;
    logic [3:0][31:0] x;
    logic [3:0]       en;
    exp_t             e;
    int               lo, hi;
    int               nstream;

    // ---- reset ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset", 16'h0);
    chk("reset.wr_addr", 32'(wr_addr), 32'h0);
    chk("reset.wr_data0", wr_data[31:0], 32'h0);
    rst = 1'b0;

    // ---- vector table ----
    //   v  en     ct                                  d                         x
    //   wen a0 d0 a1 d1 rdy bsy ret
    addv(1, 4'hF, ALL_ALU, {5'd4, 5'd3, 5'd2, 5'd1}, {32'hA3, 32'hA2, 32'hA1, 32'hA0},
         2'b00, 0, 0, 0, 0, 1, 0, 0);
    addv(0, 4'hF, ALL_ALU, {5'd31, 5'd30, 5'd29, 5'd28}, {4{32'hDEAD}},
         2'b11, 1, 32'hA0, 2, 32'hA1, 0, 1, 0);
    addv(1, 4'hF, {2'b11, 2'b00, 2'b10, 2'b01}, {5'd9, 5'd0, 5'd6, 5'd5},
         {32'h33, 32'h44, 32'h66, 32'h55},
         2'b11, 3, 32'hA2, 4, 32'hA3, 1, 1, 2);
    addv(0, 4'hF, ALL_ALU, {5'd15, 5'd14, 5'd13, 5'd12}, {4{32'hBEEF}},
         2'b01, 5, 32'h55, 0, 0, 1, 1, 4);
    addv(0, 4'h0, ALL_ALU, '0, '0,
         2'b00, 0, 0, 0, 0, 1, 0, 5);
    addv(1, 4'h3, ALL_ALU, {5'd21, 5'd20, 5'd7, 5'd7}, {32'h99, 32'h88, 32'h22, 32'h11},
         2'b00, 0, 0, 0, 0, 1, 0, 5);
    addv(0, 4'h0, ALL_ALU, '0, '0,
         2'b01, 7, 32'h22, 0, 0, 1, 1, 5);
    addv(1, 4'hF, {2'b01, 2'b00, 2'b11, 2'b10}, {5'd0, 5'd0, 5'd3, 5'd2}, {4{32'h77}},
         2'b00, 0, 0, 0, 0, 1, 0, 6);
    addv(0, 4'h0, ALL_ALU, '0, '0,
         2'b00, 0, 0, 0, 0, 1, 0, 6);
    addv(1, 4'hF, {2'b01, 2'b00, 2'b01, 2'b00}, {5'd11, 5'd10, 5'd9, 5'd8},
         {32'hB3, 32'hB2, 32'hB1, 32'hB0},
         2'b00, 0, 0, 0, 0, 1, 0, 6);
    addv(1, 4'hF, ALL_ALU, {5'd19, 5'd18, 5'd17, 5'd16}, {4{32'hC0C0}},
         2'b11, 8, 32'hB0, 9, 32'hB1, 0, 1, 6);
    addv(0, 4'h0, ALL_ALU, '0, '0,
         2'b11, 10, 32'hB2, 11, 32'hB3, 1, 1, 8);
    addv(1, 4'hD, {2'b01, 2'b00, 2'b00, 2'b01}, {5'd14, 5'd13, 5'd31, 5'd12},
         {32'hD3, 32'hD2, 32'hD1, 32'hD0},
         2'b00, 0, 0, 0, 0, 1, 0, 10);
    addv(0, 4'h0, ALL_ALU, '0, '0,
         2'b11, 12, 32'hD0, 13, 32'hD2, 0, 1, 10);
    addv(1, 4'hF, {2'b00, 2'b00, 2'b10, 2'b00}, {5'd4, 5'd3, 5'd30, 5'd3},
         {32'hE3, 32'hE2, 32'hE1, 32'hE0},
         2'b01, 14, 32'hD3, 0, 0, 1, 1, 12);
    addv(0, 4'h0, ALL_ALU, '0, '0,
         2'b01, 3, 32'hE2, 0, 0, 0, 1, 13);
    addv(0, 4'h0, ALL_ALU, '0, '0,
         2'b01, 4, 32'hE3, 0, 0, 1, 1, 14);
    addv(0, 4'h0, ALL_ALU, '0, '0,
         2'b00, 0, 0, 0, 0, 1, 0, 15);

    foreach (vq[n]) begin
      @(negedge clk);
      chk($sformatf("row%0d.wr_en", n), 32'(wr_en), 32'(vq[n].wen));
      chk($sformatf("row%0d.addr0", n), 32'(wr_addr[4:0]), 32'(vq[n].a0));
      chk($sformatf("row%0d.data0", n), wr_data[31:0], vq[n].d0);
      chk($sformatf("row%0d.addr1", n), 32'(wr_addr[9:5]), 32'(vq[n].a1));
      chk($sformatf("row%0d.data1", n), wr_data[63:32], vq[n].d1);
      chk($sformatf("row%0d.in_ready", n), 32'(in_ready), 32'(vq[n].rdy));
      chk($sformatf("row%0d.busy", n), 32'(busy), 32'(vq[n].bsy));
      chk($sformatf("row%0d.retired", n), 32'(retired), 32'(vq[n].ret));
      drive(vq[n].v, vq[n].en, vq[n].ct, vq[n].d, vq[n].x);
    end

    // ---- reset in the first drain cycle, with a bundle offered during reset ----
    @(negedge clk);
    drive(1, 4'hF, ALL_ALU, {5'd4, 5'd3, 5'd2, 5'd1}, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
    @(negedge clk);
    chk("rstmid.wr_en_before", 32'(wr_en), 32'h3);
    rst = 1'b1;
    drive(1, 4'h3, ALL_ALU, {5'd0, 5'd0, 5'd6, 5'd5}, {32'h0, 32'h0, 32'h66, 32'h65});
    @(negedge clk);
    rst = 1'b0;
    drive(0, 4'h0, ALL_ALU, '0, '0);
    chk_idle("rstmid.after", 16'h0);
    @(negedge clk);
    chk_idle("rstmid.next", 16'h0);

    // ---- back-to-back 2-write bundles up to retired = 0xFFFE ----
    nstream = 32767;
    for (int k = 0; k <= nstream; k++) begin
      @(negedge clk);
      chk("stream.in_ready", 32'(in_ready), 32'h1);
      if (k > 0) begin
        if (sb.size() == 0) begin
          chk("stream.sb_empty", 32'h0, 32'h1);
        end else begin
          e = sb.pop_front();
          chk("stream.wr_en", 32'(wr_en), 32'h3);
          chk("stream.addr0", 32'(wr_addr[4:0]), 32'(e.a0));
          chk("stream.data0", wr_data[31:0], e.d0);
          chk("stream.addr1", 32'(wr_addr[9:5]), 32'(e.a1));
          chk("stream.data1", wr_data[63:32], e.d1);
        end
      end
      if (k < nstream) begin
        case (k % 6)
          0: begin lo = 0; hi = 1; end
          1: begin lo = 0; hi = 2; end
          2: begin lo = 0; hi = 3; end
          3: begin lo = 1; hi = 2; end
          4: begin lo = 1; hi = 3; end
          default: begin lo = 2; hi = 3; end
        endcase
        en = 4'hF;
        for (int i = 0; i < 4; i++) begin
          if (i == lo || i == hi) begin
            ct[i] = ((k + i) % 2 == 1) ? 2'b01 : 2'b00;
            d[i]  = 5'(((k * 4 + i) % 31) + 1);
            x[i]  = {16'(k), 8'(i), 8'h5A};
          end else begin
            ct[i] = 2'b10;
            d[i]  = 5'd31;
            x[i]  = 32'hFFFF_0000;
          end
        end
        e.a0 = d[lo]; e.d0 = x[lo]; e.a1 = d[hi]; e.d1 = x[hi];
        sb.push_back(e);
        drive(1, en, ct, d, x);
      end else begin
        drive(0, 4'h0, ALL_ALU, '0, '0);
      end
    end
    @(negedge clk);
    chk_idle("wrap.preload", 16'hFFFE);

    // ---- four more writes wrap the counter ----
    drive(1, 4'hF, ALL_ALU, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h13, 32'h12, 32'h11, 32'h10});
    @(negedge clk);
    drive(0, 4'h0, ALL_ALU, '0, '0);
    chk("wrap.c1.wr_en", 32'(wr_en), 32'h3);
    chk("wrap.c1.in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    chk("wrap.c2.wr_en", 32'(wr_en), 32'h3);
    chk("wrap.c2.retired", 32'(retired), 32'h0000);
    @(negedge clk);
    chk_idle("wrap.done", 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: "clk  in  1  rising-edge clock"; "rst  in  1  synchronous active-high reset".
REQ-002 SHALL have parameter NLANE, default 4, meaning the number of MEM-stage lanes per bundle (fixed to 4; no other value is supported).
REQ-003 SHALL have parameter NPORT, default 2, meaning the number of register-file write ports (fixed to 2).
REQ-004 SHALL have port "in_valid  in  1  bundle offered by the MEM stage".
REQ-005 SHALL have port "in_ready  out  1  bundle accepted on clk edge when in_valid & in_ready".
REQ-006 SHALL have port "lane_en  in  [3:0]  per-lane instruction present".
REQ-007 SHALL have port "ALU_o  in  [31:0] x4  per-lane ALU result".
REQ-008 SHALL have port "IR  in  [31:0] x4  per-lane instruction".
REQ-009 SHALL have port "LMD  in  [31:0] x4  per-lane load data".
REQ-010 SHALL have port "cmd_type  in  [1:0] x4  per-lane class".
REQ-011 SHALL have port "wr_en  out  [1:0]  write strobe, one per port".
REQ-012 SHALL have port "wr_addr  out  [4:0] x2  destination register".
REQ-013 SHALL have port "wr_data  out  [31:0] x2  write data".
REQ-014 SHALL have port "busy  out  1  pending mask non-zero".
REQ-015 SHALL have port "retired  out  [15:0]  count of issued register writes, wraps".

Function
REQ-016 cmd_type decode SHALL be: 00 = ALU (dest IR[15:11], data ALU_o); 01 = load (dest IR[20:16], data LMD); 10 = store and 11 = branch/nop (no write).
REQ-017 On acceptance, the block SHALL latch all four lanes and SHALL set pending[i] = lane_en[i] & (cmd_type[i] is 00 or 01) & (dest != 0); writes to r0 are discarded at capture.
REQ-018 State SHALL be IDLE when pending == 0 and DRAIN otherwise; no other states exist.
REQ-019 In DRAIN, each cycle the block SHALL select the two lowest-index set bits of pending: port 0 gets the older lane, port 1 the younger.
REQ-020 If only one bit is set, the block SHALL drive port 0 only, with wr_en = 01.
REQ-021 If both selected lanes have the same dest, the block SHALL issue only the younger lane on port 0 (wr_en = 01) and SHALL clear both bits.
REQ-022 Issued bits SHALL clear on the same edge; DRAIN SHALL return to IDLE when pending becomes 0.
REQ-023 wr_en/wr_addr/wr_data SHALL be combinational from the latched bundle and pending; wr_en SHALL be 00 in IDLE, with wr_addr/wr_data = 0 on disabled ports.
REQ-024 First writes SHALL appear in the cycle after the acceptance edge; a 4-write bundle SHALL drain in 2 cycles.
REQ-025 in_ready SHALL equal (pending == 0) | (popcount(pending) <= 2), so back-to-back bundles with at most 2 writes each sustain one bundle per cycle.
REQ-026 When acceptance and final drain occur on the same edge, the new bundle's mask SHALL replace pending without any lost or duplicated writes.
REQ-027 A bundle with no writable lanes SHALL be accepted and SHALL leave the block in IDLE.
REQ-028 retired SHALL add the number of wr_en bits set each cycle, modulo 2^16 (0xFFFF + 2 = 0x0001).
REQ-029 Input values SHALL be ignored when in_valid & in_ready is false.

Reset
REQ-030 While rst is high at a clk edge: pending = 0, state = IDLE, retired = 0, latched bundle = 0.
REQ-031 During and after reset: wr_en = 00, busy = 0, in_ready = 1.
REQ-032 Reset mid-DRAIN SHALL abandon all pending writes, with no wr_en asserted in the following cycle.
REQ-033 A bundle offered during the reset cycle SHALL NOT be accepted.

Verification
REQ-034 Four ALU lanes, rd = 1,2,3,4, data 0xA0..0xA3 -> cycle 1: (r1,0xA0),(r2,0xA1); cycle 2: (r3,0xA2),(r4,0xA3); retired = 4; in_ready low in cycle 1.
REQ-035 Lane0 load rt=5 LMD=0x55, lane1 store, lane2 ALU rd=0, lane3 nop -> a single write (r5,0x55) on port 0 only; IDLE next cycle.
REQ-036 Lanes 0 and 1 both ALU rd=7, data 0x11 and 0x22 -> only (r7,0x22) is written, with wr_en = 01.
REQ-037 Continuous in_valid with 2 writes per bundle -> one bundle accepted per cycle, in_ready held high, no write lost (checked against a scoreboard).
REQ-038 rst asserted in the first DRAIN cycle of a 4-write bundle -> no writes in later cycles, retired = 0, in_ready = 1.
REQ-039 Preload retired to 0xFFFE via 2-write bundles, then issue 4 writes -> retired = 0x0002.
